// File: rtl/tone_decoder_if.sv
// Speaker input and decoded-note outputs of tone_decoder.
// The decoder uses the slave modport; the tone source or bench uses master.
interface tone_decoder_if #(
    parameter int unsigned CNT_W = 18
);
    logic             speaker;
    logic [3:0]       key;
    logic             note_valid;
    logic             note_change;
    logic [CNT_W-1:0] period_out;

    modport master (
        output speaker,
        input  key,
        input  note_valid,
        input  note_change,
        input  period_out
    );

    modport slave (
        input  speaker,
        output key,
        output note_valid,
        output note_change,
        output period_out
    );
endinterface

// File: rtl/tone_decoder.sv
// Square-wave note recognizer: measures the half-period between speaker edges and reports
// a one-hot key once LOCK_N consecutive half-periods match the same configured note.
module tone_decoder #(
    parameter int unsigned CNT_W   = 18,
    parameter int unsigned HALF1   = 95420,
    parameter int unsigned HALF2   = 85034,
    parameter int unsigned HALF3   = 75757,
    parameter int unsigned HALF4   = 71633,
    parameter int unsigned TOL     = 500,
    parameter int unsigned LOCK_N  = 4,
    parameter int unsigned TIMEOUT = 200000
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_decoder_if.slave bus
);
    localparam int unsigned      RUN_W    = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_N);
    localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(LOCK_N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StArmed, StTrack, StLocked} state_e;

    state_e           r_state, w_state_d;
    logic             r_sync1, r_sync2, r_prev;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [CNT_W-1:0] r_period, w_period_d;
    logic [RUN_W-1:0] r_run, w_run_d;
    logic [2:0]       r_cand, w_cand_d, w_class;
    logic [3:0]       r_key, w_key_d;
    logic             r_valid, r_change;
    logic             w_edge, w_locked;

    function automatic logic near(input logic [CNT_W-1:0] l, input int unsigned half);
        int unsigned v;
        v = 32'(l);
        return (v + TOL >= half) && (v <= half + TOL);
    endfunction

    assign w_edge = r_sync2 ^ r_prev;

    // A saturated count is never a note; lowest index wins on overlap.
    always_comb begin
        w_class = 3'd0;
        if (r_cnt != CNT_MAX) begin
            if (near(r_cnt, HALF1)) begin
                w_class = 3'd1;
            end else if (near(r_cnt, HALF2)) begin
                w_class = 3'd2;
            end else if (near(r_cnt, HALF3)) begin
                w_class = 3'd3;
            end else if (near(r_cnt, HALF4)) begin
                w_class = 3'd4;
            end
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        w_period_d = r_period;
        w_run_d    = r_run;
        w_cand_d   = r_cand;
        if (w_edge) begin
            w_cnt_d = CNT_W'(1);
            if (r_state != StIdle) begin
                w_period_d = r_cnt;
            end
            unique case (r_state)
                StIdle: w_state_d = StArmed;
                StArmed: begin
                    if (w_class != 3'd0) begin
                        w_cand_d = w_class;
                        if (LOCK_N == 1) begin
                            w_state_d = StLocked;
                            w_run_d   = RUN_LOCK;
                        end else begin
                            w_state_d = StTrack;
                            w_run_d   = RUN_W'(1);
                        end
                    end
                end
                StTrack, StLocked: begin
                    if (w_class == 3'd0) begin
                        w_state_d = StArmed;
                        w_run_d   = '0;
                    end else if (w_class != r_cand) begin
                        w_state_d = StTrack;
                        w_cand_d  = w_class;
                        w_run_d   = RUN_W'(1);
                    end else if (r_state == StTrack) begin
                        if (r_run >= RUN_PRE) begin
                            w_state_d = StLocked;
                            w_run_d   = RUN_LOCK;
                        end else begin
                            w_run_d = r_run + RUN_W'(1);
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end else if (r_state != StIdle && r_cnt >= CNT_TO) begin
            w_state_d = StIdle;
            w_run_d   = '0;
            w_cand_d  = '0;
        end
    end

    // Outputs follow the registered state, one cycle behind the FSM.
    always_comb begin
        w_locked = (r_state == StLocked);
        w_key_d  = 4'b0000;
        if (w_locked) begin
            case (r_cand)
                3'd1:    w_key_d = 4'b0001;
                3'd2:    w_key_d = 4'b0010;
                3'd3:    w_key_d = 4'b0100;
                3'd4:    w_key_d = 4'b1000;
                default: w_key_d = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_period <= '0;
            r_run    <= '0;
            r_cand   <= '0;
            r_key    <= 4'b0000;
            r_valid  <= 1'b0;
            r_change <= 1'b0;
        end else begin
            r_sync1  <= bus.speaker;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_period <= w_period_d;
            r_run    <= w_run_d;
            r_cand   <= w_cand_d;
            r_key    <= w_key_d;
            r_valid  <= w_locked;
            r_change <= w_locked & ~r_valid;
        end
    end

    assign bus.key         = r_key;
    assign bus.note_valid  = r_valid;
    assign bus.note_change = r_change;
    assign bus.period_out  = r_period;
endmodule
